// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: iterative rotation-mode CORDIC engine with atan ROM sequencing.
// Optional gain compensation under CORDIC_GAIN_COMP_EN. Rev 1.0
`default_nettype none

module cordic_iter_ctrl #(
  parameter int DW   = 16,
  parameter int AW   = 4,
  parameter int ITER = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] y_in,
  input  logic [DW-1:0] z_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW+1:0] x_out,
  output logic [DW+1:0] y_out,
  output logic [DW-1:0] z_out,
  output logic          busy,
  output logic [AW-1:0] atan_addr,
  input  logic [DW-1:0] atan_val
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd3;
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [1:0] S_SCALE = 2'd2;
  localparam logic signed [DW-1:0] GAIN_K = DW'(16'h26DD);
`endif
  localparam logic [AW:0] LAST_CNT = (AW+1)'(ITER - 1);

  logic [1:0]           state;
  logic [AW:0]          cnt;
  logic signed [DW+1:0] x_r;
  logic signed [DW+1:0] y_r;
  logic signed [DW-1:0] z_r;

  logic                 dir_pos;
  logic signed [DW+1:0] x_sh;
  logic signed [DW+1:0] y_sh;

  // z == 0 rotates in the positive direction
  assign dir_pos = ~z_r[DW-1];
  assign x_sh    = x_r >>> cnt[AW-1:0];
  assign y_sh    = y_r >>> cnt[AW-1:0];

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [2*DW+1:0] x_prod;
  logic signed [2*DW+1:0] y_prod;
  assign x_prod = x_r * GAIN_K;
  assign y_prod = y_r * GAIN_K;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      x_r   <= '0;
      y_r   <= '0;
      z_r   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_r   <= {{2{x_in[DW-1]}}, x_in};
            y_r   <= {{2{y_in[DW-1]}}, y_in};
            z_r   <= z_in;
            cnt   <= '0;
            state <= S_ITER;
          end
        end
        S_ITER: begin
          x_r <= dir_pos ? (x_r - y_sh) : (x_r + y_sh);
          y_r <= dir_pos ? (y_r + x_sh) : (y_r - x_sh);
          z_r <= dir_pos ? (z_r - atan_val) : (z_r + atan_val);
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= S_SCALE;
`else
            state <= S_DONE;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        S_SCALE: begin
          x_r   <= (DW+2)'(x_prod >>> 14);
          y_r   <= (DW+2)'(y_prod >>> 14);
          state <= S_DONE;
        end
`endif
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // All outputs are held quiet while reset is asserted, even before the edge
  assign in_ready  = rst_n && (state == S_IDLE);
  assign out_valid = rst_n && (state == S_DONE);
  assign busy      = rst_n && (state != S_IDLE);
  assign atan_addr = (rst_n && (state == S_ITER)) ? cnt[AW-1:0] : '0;
  assign x_out     = rst_n ? x_r : '0;
  assign y_out     = rst_n ? y_r : '0;
  assign z_out     = rst_n ? z_r : '0;

endmodule

`default_nettype wire

// File: tb/tb_cordic_iter_ctrl.sv
// tb_cordic_iter_ctrl: scoreboard bench for cordic_iter_ctrl (CORDIC_GAIN_COMP_EN aware).
`default_nettype none

module tb_cordic_iter_ctrl;

  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int ITER = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT  = ITER + 2;
  localparam int G1   = 16384;   // unit x after rotation
  localparam int GP4  = 11585;   // 16384*cos(pi/4)
  localparam int GC6  = 14189;   // 16384*cos(pi/6)
  localparam int GS6  = 8192;    // 16384*sin(pi/6)
`else
  localparam int LAT  = ITER + 1;
  localparam int G1   = 26981;   // 16384*1.64676
  localparam int GP4  = 19079;
  localparam int GC6  = 23366;
  localparam int GS6  = 13490;
`endif

  typedef struct {
    int x;
    int y;
    int z;
    int tol;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] x_in = '0;
  logic [DW-1:0] y_in = '0;
  logic [DW-1:0] z_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW+1:0] x_out;
  logic [DW+1:0] y_out;
  logic [DW-1:0] z_out;
  logic          busy;
  logic [AW-1:0] atan_addr;
  logic [DW-1:0] atan_val;

  logic [DW-1:0] rom [16];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs_time = 0;

  cordic_iter_ctrl #(.DW(DW), .AW(AW), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid),
    .out_ready(out_ready), .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .busy(busy), .atan_addr(atan_addr), .atan_val(atan_val)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign atan_val = rom[atan_addr];

  initial begin
    rom[0]  = 16'd12868; rom[1]  = 16'd7596; rom[2]  = 16'd4014; rom[3]  = 16'd2037;
    rom[4]  = 16'd1023;  rom[5]  = 16'd512;  rom[6]  = 16'd256;  rom[7]  = 16'd128;
    rom[8]  = 16'd64;    rom[9]  = 16'd32;   rom[10] = 16'd16;   rom[11] = 16'd8;
    rom[12] = 16'd4;     rom[13] = 16'd2;    rom[14] = 16'd1;    rom[15] = 16'd1;
  end

  task automatic chk(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (+/-%0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  // Monitor: pops one expectation per accepted result
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("x_out", $signed(x_out), e.x, e.tol);
        chk("y_out", $signed(y_out), e.y, e.tol);
        chk("z_out", $signed(z_out), e.z, 4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int xi, input int yi, input int zi, input bit push,
                       input exp_t e, input bit hold);
    int n = 0;
    in_valid = 1'b1;
    x_in = DW'(xi);
    y_in = DW'(yi);
    z_in = DW'(zi);
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("handshake_timeout", int'(in_ready), 1, 0);
    if (push) sb.push_back(e);
    hs_time = cyc;
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_remaining", sb.size(), 0, 0);
  endtask

  initial begin
    exp_t e_zero, e_p4, e_n4, e_p6, e_p2, e_none;
    int   t_prev, n;
    logic [DW+1:0] hx, hy;
    logic [DW-1:0] hz;
    e_zero = '{x: G1,  y: 0,    z: 0, tol: 8};
    e_p4   = '{x: GP4, y: GP4,  z: 0, tol: 8};
    e_n4   = '{x: GP4, y: -GP4, z: 0, tol: 8};
    e_p6   = '{x: GC6, y: GS6,  z: 0, tol: 16};
    e_p2   = '{x: 0,   y: G1,   z: 0, tol: 16};
    e_none = '{x: 0,   y: 0,    z: 0, tol: 0};

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", int'(in_ready), 0, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_addr", int'(atan_addr), 0, 0);
    chk("rst_x_out", int'(x_out), 0, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", int'(in_ready), 1, 0);
    tick();

    // Address sequence and latency on a zero rotation
    issue(16384, 0, 0, 1'b1, e_zero, 1'b0);
    for (int k = 1; k <= LAT; k++) begin
      chk("addr_seq", int'(atan_addr), (k <= ITER) ? k - 1 : 0, 0);
      chk("latency_valid", int'(out_valid), (k == LAT) ? 1 : 0, 0);
      if (k <= ITER) chk("busy_iter", int'(busy), 1, 0);
      if (k < LAT) tick();
    end
    drain();

    // +/- pi/4
    issue(16384, 0, 16'h3244, 1'b1, e_p4, 1'b0);
    drain();
    issue(16384, 0, -12868, 1'b1, e_n4, 1'b0);
    drain();

    // Backpressure on a pi/6 result
    out_ready = 1'b0;
    issue(16384, 0, 8579, 1'b1, e_p6, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("bp_out_valid", int'(out_valid), 1, 0);
    hx = x_out; hy = y_out; hz = z_out;
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      z_in = 16'h1111;
      tick();
      chk("bp_x_stable", int'(x_out), int'(hx), 0);
      chk("bp_y_stable", int'(y_out), int'(hy), 0);
      chk("bp_z_stable", int'(z_out), int'(hz), 0);
      chk("bp_in_ready", int'(in_ready), 0, 0);
      chk("bp_busy", int'(busy), 1, 0);
      chk("bp_valid_held", int'(out_valid), 1, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_idle", int'(in_ready), 1, 0);
    chk("bp_release_valid", int'(out_valid), 0, 0);
    issue(16384, 0, 25736, 1'b1, e_p2, 1'b0);
    drain();

    // Reset at iteration 7 aborts the operation
    issue(16384, 0, 16'h3244, 1'b0, e_none, 1'b0);
    repeat (7) tick();
    chk("mid_addr_before_rst", int'(atan_addr), 7, 0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_out_valid", int'(out_valid), 0, 0);
    chk("mid_rst_busy", int'(busy), 0, 0);
    chk("mid_rst_addr", int'(atan_addr), 0, 0);
    chk("mid_rst_x", int'(x_out), 0, 0);
    chk("mid_rst_y", int'(y_out), 0, 0);
    chk("mid_rst_z", int'(z_out), 0, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 1, 0);
    tick();
    issue(16384, 0, 16'h3244, 1'b1, e_p4, 1'b0);
    drain();

    // Back-to-back with in_valid held high
    issue(16384, 0, 0, 1'b1, e_zero, 1'b1);
    t_prev = hs_time;
    issue(16384, 0, 8579, 1'b1, e_p6, 1'b1);
    chk("b2b_interval1", hs_time - t_prev, LAT + 1, 0);
    t_prev = hs_time;
    issue(16384, 0, -12868, 1'b1, e_n4, 1'b1);
    chk("b2b_interval2", hs_time - t_prev, LAT + 1, 0);
    t_prev = hs_time;
    issue(16384, 0, 25736, 1'b1, e_p2, 1'b0);
    chk("b2b_interval3", hs_time - t_prev, LAT + 1, 0);
    drain();
    repeat (LAT + 4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
